// File: rtl/truth_table_sweep.sv
// Purpose : drives all 32 {a,b,c,d,e} vectors into a 5-input logic block, samples z back,
//           and builds the truth table, a ones count and a first-mismatch index against EXPECTED.
// Latency : 32*(SETTLE+1) cycles from the accepted start to done.
// Backpr. : none; start is a one-cycle request that is ignored while busy.
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   start      one-cycle request to begin a sweep (accepted in IDLE or DONE)
//   z_in       z output of the logic block under sweep
//   vec        drives {a,b,c,d,e}; a = bit 4, e = bit 0
//   busy       high while a sweep is in progress
//   done       high from sweep completion until the next accepted start or reset
//   tt         captured truth table; bit i = z_in sampled for vec = i
//   ones       count of ones captured so far (0..32)
//   mismatch   sticky flag: some captured bit differs from EXPECTED
//   first_bad  index of the first mismatching vector; meaningful only when mismatch = 1

`timescale 1ns/1ps

module truth_table_sweep #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [31:0] EXPECTED = 32'hFF14_1414
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        z_in,
  output logic [4:0]  vec,
  output logic        busy,
  output logic        done,
  output logic [31:0] tt,
  output logic [5:0]  ones,
  output logic        mismatch,
  output logic [4:0]  first_bad
);

  // Settle counter is 4 bits, so SETTLE is meaningful over 0..15.
  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] settle_cnt;

  // Helpers for the sample edge: the last settle cycle of the current vector.
  logic sample_now;
  logic last_vec;
  logic bit_bad;

  assign sample_now = (settle_cnt == SETTLE_LIM);
  assign last_vec   = (vec == 5'd31);
  assign bit_bad    = (z_in != EXPECTED[vec]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= 4'd0;
      vec        <= 5'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt         <= 32'd0;
      ones       <= 6'd0;
      mismatch   <= 1'b0;
      first_bad  <= 5'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // Results hold in DONE until a new start clears them.
          if (start) begin
            state      <= ST_RUN;
            settle_cnt <= 4'd0;
            vec        <= 5'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
            tt         <= 32'd0;
            ones       <= 6'd0;
            mismatch   <= 1'b0;
            first_bad  <= 5'd0;
          end
        end

        ST_RUN: begin
          // start is deliberately not looked at here: a sweep cannot be
          // restarted or queued from inside another sweep.
          if (!sample_now) begin
            settle_cnt <= settle_cnt + 4'd1;
          end else begin
            tt[vec]    <= z_in;
            ones       <= ones + 6'(z_in);
            settle_cnt <= 4'd0;
            // Only the first mismatch of a sweep is recorded.
            if (bit_bad && !mismatch) begin
              mismatch  <= 1'b1;
              first_bad <= vec;
            end
            if (last_vec) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              vec   <= 5'd0;
            end else begin
              vec <= vec + 5'd1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Purpose : scoreboard bench for truth_table_sweep; two instances (SETTLE=1 and SETTLE=0)
//           are fed golden, faulty and random truth tables through a table-driven z_in.
// Latency : expected done latency per sweep is 32*(SETTLE+1) cycles after the start edge.
// Backpr. : none; the monitor pops one expected result per rising edge of done.

`timescale 1ns/1ps

module tb_truth_table_sweep;

  localparam logic [31:0] EXP_TBL = 32'hFF14_1414;
  localparam int S0 = 1;
  localparam int S1 = 0;

  typedef struct {
    logic [31:0] tt;
    logic [5:0]  ones;
    logic        mm;
    logic [4:0]  fb;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_w;
  logic [1:0]       start_w;
  logic [1:0]       z_w;
  logic [1:0][4:0]  vec_w;
  logic [1:0]       busy_w;
  logic [1:0]       done_w;
  logic [1:0][31:0] tt_w;
  logic [1:0][5:0]  ones_w;
  logic [1:0]       mm_w;
  logic [1:0][4:0]  fb_w;
  logic [1:0][31:0] drv_tbl;

  // The block under sweep is modelled as a lookup of drv_tbl by the driven vector.
  assign z_w[0] = drv_tbl[0][vec_w[0]];
  assign z_w[1] = drv_tbl[1][vec_w[1]];

  truth_table_sweep #(.SETTLE(S0), .EXPECTED(EXP_TBL)) dut0 (
    .clk(clk), .rst(rst_w[0]), .start(start_w[0]), .z_in(z_w[0]),
    .vec(vec_w[0]), .busy(busy_w[0]), .done(done_w[0]), .tt(tt_w[0]),
    .ones(ones_w[0]), .mismatch(mm_w[0]), .first_bad(fb_w[0])
  );

  truth_table_sweep #(.SETTLE(S1), .EXPECTED(EXP_TBL)) dut1 (
    .clk(clk), .rst(rst_w[1]), .start(start_w[1]), .z_in(z_w[1]),
    .vec(vec_w[1]), .busy(busy_w[1]), .done(done_w[1]), .tt(tt_w[1]),
    .ones(ones_w[1]), .mismatch(mm_w[1]), .first_bad(fb_w[1])
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   start_cyc [2];
  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] done_prev = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // z = (a & b) | ((c ^ d) & ~e) evaluated for every input combination.
  function automatic logic [31:0] golden_tbl();
    logic [31:0] t;
    for (int i = 0; i < 32; i++) begin
      logic a, b, c, d, e;
      a = i[4]; b = i[3]; c = i[2]; d = i[1]; e = i[0];
      t[i] = (a & b) | ((c ^ d) & ~e);
    end
    return t;
  endfunction

  function automatic exp_t model(input logic [31:0] tbl, input int settle);
    exp_t r;
    r.tt   = tbl;
    r.ones = 6'($countones(tbl));
    r.mm   = 1'b0;
    r.fb   = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (!r.mm && (tbl[i] != EXP_TBL[i])) begin
        r.mm = 1'b1;
        r.fb = 5'(i);
      end
    end
    r.lat = 32 * (settle + 1);
    return r;
  endfunction

  function automatic int settle_of(input int d);
    return (d == 0) ? S0 : S1;
  endfunction

  task automatic flush(input int d);
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  task automatic check_reset(input int d);
    check($sformatf("rst_vec_d%0d", d),  vec_w[d],  0);
    check($sformatf("rst_busy_d%0d", d), busy_w[d], 0);
    check($sformatf("rst_done_d%0d", d), done_w[d], 0);
    check($sformatf("rst_tt_d%0d", d),   tt_w[d],   0);
    check($sformatf("rst_ones_d%0d", d), ones_w[d], 0);
    check($sformatf("rst_mm_d%0d", d),   mm_w[d],   0);
    check($sformatf("rst_fb_d%0d", d),   fb_w[d],   0);
  endtask

  // Issue an accepted start; returns #1 after the start edge (edge 0).
  task automatic start_sweep(input int d, input logic [31:0] tbl);
    @(negedge clk);
    drv_tbl[d] = tbl;
    if (d == 0) q0.push_back(model(tbl, settle_of(d)));
    else        q1.push_back(model(tbl, settle_of(d)));
    start_w[d] = 1'b1;
    @(posedge clk);
    #1;
    start_cyc[d] = cyc;
    start_w[d]   = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    int n;
    n = 0;
    while (!done_w[d] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("done_within_budget_d%0d", d), done_w[d], 1);
  endtask

  // Monitor: on each rising done, pop the oldest expectation and compare.
  always @(negedge clk) begin
    exp_t e;
    int   sz;
    for (int d = 0; d < 2; d++) begin
      if (done_w[d] && !done_prev[d]) begin
        sz = (d == 0) ? q0.size() : q1.size();
        check($sformatf("sb_has_entry_d%0d", d), (sz > 0), 1);
        if (sz > 0) begin
          if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
          check($sformatf("tt_d%0d", d),      tt_w[d],   e.tt);
          check($sformatf("ones_d%0d", d),    ones_w[d], 32'(e.ones));
          check($sformatf("mismatch_d%0d", d), mm_w[d],  32'(e.mm));
          check($sformatf("first_bad_d%0d", d), fb_w[d], 32'(e.fb));
          check($sformatf("busy_at_done_d%0d", d), busy_w[d], 0);
          check($sformatf("vec_at_done_d%0d", d),  vec_w[d],  0);
          check($sformatf("latency_d%0d", d), 32'(cyc - start_cyc[d]), 32'(e.lat));
        end
      end
      done_prev[d] = done_w[d];
    end
  end

  initial begin
    logic [31:0] g;
    logic [31:0] r;
    g       = golden_tbl();
    rst_w   = 2'b11;
    start_w = 2'b00;
    drv_tbl = '0;
    repeat (3) @(negedge clk);
    rst_w = 2'b00;
    check_reset(0);
    check_reset(1);

    // Golden, stuck-at-0 and inverted sweeps with SETTLE = 1.
    start_sweep(0, g);
    wait_done(0, 80);
    repeat (3) @(negedge clk);
    check("tt_holds_in_done", tt_w[0], 32'hFF14_1414);
    check("done_holds", done_w[0], 1);
    start_sweep(0, 32'd0);
    wait_done(0, 80);
    start_sweep(0, ~g);
    wait_done(0, 80);

    // Reset 20 cycles into a sweep, then a clean golden sweep.
    start_sweep(0, g);
    repeat (19) @(negedge clk);
    rst_w[0] = 1'b1;
    flush(0);
    @(negedge clk);
    rst_w[0] = 1'b0;
    check_reset(0);
    start_sweep(0, g);
    wait_done(0, 80);

    // Second start at cycle 10 of a sweep must be ignored.
    start_sweep(0, g);
    repeat (10) @(negedge clk);
    start_w[0] = 1'b1;
    @(posedge clk);
    #1;
    start_w[0] = 1'b0;
    @(negedge clk);
    check("vec_after_ignored_start", vec_w[0], 5);
    check("busy_after_ignored_start", busy_w[0], 1);
    wait_done(0, 80);

    // Random tables on both instances: full random, single and double flips of golden.
    for (int k = 0; k < 6; k++) begin
      r = $urandom();
      if (k % 3 == 1) r = g ^ (32'd1 << $urandom_range(31, 0));
      if (k % 3 == 2) r = g ^ (32'd1 << $urandom_range(31, 0)) ^ (32'd1 << $urandom_range(31, 0));
      start_sweep(0, r);
      wait_done(0, 80);
      start_sweep(1, r);
      wait_done(1, 48);
    end

    // SETTLE = 0: golden sweep, then restart from DONE.
    start_sweep(1, g);
    wait_done(1, 48);
    start_sweep(1, g);
    check("restart_done_clr", done_w[1], 0);
    check("restart_tt_clr",   tt_w[1],   0);
    check("restart_ones_clr", ones_w[1], 0);
    check("restart_busy",     busy_w[1], 1);
    wait_done(1, 48);

    // start on the very edge that enters DONE is ignored.
    start_sweep(1, ~g);
    while (cyc < start_cyc[1] + 31) @(negedge clk);
    start_w[1] = 1'b1;
    @(posedge clk);
    #1;
    start_w[1] = 1'b0;
    @(negedge clk);
    check("edge_start_done", done_w[1], 1);
    check("edge_start_busy", busy_w[1], 0);
    @(negedge clk);
    check("edge_start_done_holds", done_w[1], 1);
    check("edge_start_tt_holds", tt_w[1], ~g);

    // rst and start together: reset wins, block stays idle.
    @(negedge clk);
    rst_w[1]   = 1'b1;
    start_w[1] = 1'b1;
    @(negedge clk);
    rst_w[1]   = 1'b0;
    start_w[1] = 1'b0;
    check_reset(1);
    @(negedge clk);
    check("idle_after_rst_start", busy_w[1], 0);

    repeat (2) @(negedge clk);
    check("sb_drained_d0", q0.size(), 0);
    check("sb_drained_d1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sweep.md
# truth_table_sweep

Self-checking sweep stage wrapped around the 5-input combinational logic block `z = (a & b) | ((c ^ d) & ~e)`. On a start pulse it drives all 32 input combinations onto `{a,b,c,d,e}`, waits a programmable settle time, and samples `z` back. It assembles the captured 32-bit truth table, counts the ones, and compares the result bit-by-bit against an expected table. It is both the upstream driver and the downstream consumer of that block, and replaces the open-loop testbench sweep with synthesizable hardware.

## Interface

- `SETTLE`, default 1: extra hold cycles per vector before sampling; legal range 0..15.
- `EXPECTED`, default 32'hFF14_1414: expected truth table; bit i = expected `z` for `{a,b,c,d,e}` = i.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep.
- `z_in`  in  1  output `z` of the logic block under sweep.
- `vec`  out  5  drives `{a,b,c,d,e}` (a = bit 4, e = bit 0).
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high from sweep completion until the next accepted start or reset.
- `tt`  out  32  captured truth table; bit i = sampled `z_in` for vec = i.
- `ones`  out  6  number of 1s captured so far (0..32).
- `mismatch`  out  1  sticky; set when any captured bit differs from `EXPECTED`.
- `first_bad`  out  5  index of the first mismatching vector; valid only when `mismatch` = 1.

## Operation

- The clock is one clock domain. Reset is synchronous and active-high.
- States:
  - IDLE: initial state.
  - RUN: sweep in progress.
  - DONE: sweep complete.
- Reset values:
  - `vec` = 0, `busy` = 0, `done` = 0, `tt` = 0, `ones` = 0, `mismatch` = 0, `first_bad` = 0.
  - State = IDLE, settle counter = 0.
- IDLE or DONE, `start` = 1:
  - Go to RUN.
  - Clear `tt`, `ones`, `mismatch`, `first_bad`, `done`, and the settle counter.
  - Set `vec` = 0 and `busy` = 1.
- RUN, settle counter < `SETTLE`: increment the counter; `vec` is held.
- RUN, settle counter == `SETTLE` (sample edge):
  - Write `tt[vec]` = `z_in`.
  - Add `z_in` to `ones`.
  - If `z_in` != `EXPECTED[vec]` and `mismatch` = 0: set `mismatch` = 1 and `first_bad` = `vec`.
  - Reset the settle counter.
  - If `vec` == 31: go to DONE, `busy` = 0, `done` = 1, `vec` = 0.
  - Otherwise: `vec` = `vec` + 1.
- `start` while in RUN is ignored; it neither restarts nor queues a sweep.
- In DONE, all results hold until `start` or `rst`.
- `vec` is 5 bits and never wraps during a sweep; the final-vector check uses `vec` == 31.
- `ones` is 6 bits and saturates naturally at 32; no overflow is possible.
- `first_bad` is written only once per sweep.

## Timing

- Each vector occupies `SETTLE`+1 cycles. `z_in` is sampled at the rising edge that ends the last of those cycles.
- Edge numbering: `start` is sampled at edge 0, so `vec` = 0 is visible after edge 0. The sample of vector i occurs at edge (i+1)·(`SETTLE`+1).
- Sweep latency: `done` rises after edge 32·(`SETTLE`+1).
  - `SETTLE` = 1: 64 cycles.
  - `SETTLE` = 0: 32 cycles.
- `z_in` is purely combinational from `vec`, so `SETTLE` = 0 is functionally correct. Larger values tolerate registered or slow paths.
- `tt` and `ones` update progressively during RUN. They are final only when `done` = 1.
- `rst` mid-sweep takes effect at the next edge and returns every output to its reset value. The partial sweep is discarded.
- `rst` and `start` asserted in the same cycle: `rst` wins and the block stays in IDLE.
- `start` in the same cycle that DONE is entered (the edge of the sample of vector 31): ignored, because the state is still RUN.

## Test plan

- **Golden sweep.** Connect the real logic block, `SETTLE` = 1, pulse `start`.
  - Expect `done` after 64 cycles, `tt` = 32'hFF141414, `ones` = 14, `mismatch` = 0, `busy` = 0, `vec` = 0.
- **Stuck-at-0 output.** Tie `z_in` = 0.
  - Expect `tt` = 0, `ones` = 0, `mismatch` = 1, `first_bad` = 2.
- **Inverted output.** Drive `z_in` = ~z.
  - Expect `tt` = 32'h00EBEBEB, `ones` = 18, `mismatch` = 1, `first_bad` = 0.
- **Reset mid-sweep.** Assert `rst` for one cycle 20 cycles after `start`.
  - Expect all outputs at reset values on the next cycle.
  - A new `start` then yields the golden result after 64 cycles.
- **Start while busy.** Pulse `start` again at cycle 10 of a sweep.
  - Expect no restart; `done` still rises after cycle 64 with the golden result.
- **Zero settle and restart from DONE.** Build with `SETTLE` = 0.
  - Expect the golden result after 32 cycles.
  - A `start` issued in DONE clears `done`, `tt`, and `ones` at the next edge and re-runs the sweep.
